// File: rtl/qr_pkg.sv
// qr_pkg: constants and helpers shared by the QR datapath blocks.
//   ST_IDLE / ST_RUN / ST_FIN : divider FSM state encoding
//   QR_WIDTH / QR_FRAC        : default fixed-point format (Q8.8)
//   qr_sat_pos / qr_sat_neg   : saturation limits for a given width
package qr_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam int QR_WIDTH = 16;
  localparam int QR_FRAC  = 8;

  // Largest representable value: 2^(w-1)-1 when signed, 2^w-1 when unsigned.
  // Returned 64 bits wide so callers can size it to any format up to 63 bits.
  function automatic logic [63:0] qr_sat_pos(input int w, input int sgn);
    if (sgn != 0) begin
      return (64'd1 << (w - 1)) - 64'd1;
    end
    return (64'd1 << w) - 64'd1;
  endfunction

  // Magnitude of the most negative signed value, 2^(w-1). As a w-bit pattern
  // this is also the 0x80..0 saturation code.
  function automatic logic [63:0] qr_sat_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/qr_div_step.sv
// qr_div_step: one combinational restoring-division step.
//   rem_in  : partial remainder, always < divisor
//   divisor : |b|
//   din     : next dividend bit, shifted into the remainder LSB
//   rem_out : new partial remainder
//   q_bit   : quotient bit produced by this step
module qr_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             din,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // Because rem_in < divisor, trial <= 2*divisor-1, so a successful subtract
  // leaves diff < 2^WIDTH (MSB clear) and a failed one wraps negative (MSB set).
  // The difference MSB therefore doubles as the compare result.
  always_comb begin
    trial   = {rem_in, din};
    diff    = trial - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/qr_fxp_divider.sv
// qr_fxp_divider: iterative fixed-point divider, q = (a << FRAC) / b,
// one quotient bit per clock.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_start      : request, taken only in IDLE or FIN
//   i_a, i_b     : dividend / divisor, captured on the accepted start
//   o_busy       : high while iterating
//   o_done       : one-cycle result strobe
//   o_q          : quotient, held until the next result
//   o_div0       : last result was a divide by zero
//   o_ovf        : last result was out of range (saturated or wrapped)
module qr_fxp_divider
  import qr_pkg::*;
#(
  parameter int WIDTH  = QR_WIDTH,
  parameter int FRAC   = QR_FRAC,
  parameter int SIGNED = 1,
  parameter int SAT    = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_q,
  output logic             o_div0,
  output logic             o_ovf
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N);

  // Range limits on the N-bit magnitude quotient, and the saturation codes.
  localparam logic [N-1:0]     MAG_POS_LIM = N'(qr_sat_pos(WIDTH, SIGNED));
  localparam logic [N-1:0]     MAG_NEG_LIM = N'(qr_sat_neg(WIDTH));
  localparam logic [WIDTH-1:0] Q_POS_SAT   = WIDTH'(qr_sat_pos(WIDTH, SIGNED));
  localparam logic [WIDTH-1:0] Q_NEG_SAT   = WIDTH'(qr_sat_neg(WIDTH));

  logic [1:0]       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] div_reg;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
  // after N steps this register holds the magnitude quotient.
  logic [N-1:0]     sreg_reg;
  logic             neg_reg;
  logic [WIDTH-1:0] q_reg;
  logic             div0_reg;
  logic             ovf_reg;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [N-1:0]     dvd_start;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [N-1:0]     mag;
  logic [WIDTH-1:0] mag_lo;
  logic [WIDTH-1:0] wrap_q;
  logic             res_ovf;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] div0_q;

  // Negating 0x80..0 gives 0x80..0, which read unsigned is exactly 2^(W-1),
  // so the most negative operand needs no extra bit.
  always_comb begin
    a_neg     = (SIGNED != 0) && i_a[WIDTH-1];
    b_neg     = (SIGNED != 0) && i_b[WIDTH-1];
    abs_a     = a_neg ? -i_a : i_a;
    abs_b     = b_neg ? -i_b : i_b;
    dvd_start = N'(abs_a) << FRAC;
    div0_q    = a_neg ? Q_NEG_SAT : Q_POS_SAT;
  end

  qr_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (rem_reg),
    .divisor(div_reg),
    .din    (sreg_reg[N-1]),
    .rem_out(step_rem),
    .q_bit  (step_q)
  );

  // Result formed from the last step's output so it can be registered on the
  // same edge that enters FIN.
  always_comb begin
    mag     = {sreg_reg[N-2:0], step_q};
    mag_lo  = mag[WIDTH-1:0];
    wrap_q  = neg_reg ? -mag_lo : mag_lo;
    res_ovf = neg_reg ? (mag > MAG_NEG_LIM) : (mag > MAG_POS_LIM);
    if (res_ovf && (SAT != 0)) begin
      res_q = neg_reg ? Q_NEG_SAT : Q_POS_SAT;
    end else begin
      res_q = wrap_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      rem_reg   <= '0;
      div_reg   <= '0;
      sreg_reg  <= '0;
      neg_reg   <= 1'b0;
      q_reg     <= '0;
      div0_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_FIN: begin
          if (i_start) begin
            if (i_b == '0) begin
              state_reg <= ST_FIN;
              q_reg     <= div0_q;
              div0_reg  <= 1'b1;
              ovf_reg   <= 1'b0;
            end else begin
              state_reg <= ST_RUN;
              cnt_reg   <= CW'(N - 1);
              rem_reg   <= '0;
              div_reg   <= abs_b;
              sreg_reg  <= dvd_start;
              neg_reg   <= a_neg ^ b_neg;
            end
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_RUN: begin
          rem_reg  <= step_rem;
          sreg_reg <= mag;
          cnt_reg  <= cnt_reg - CW'(1);
          if (cnt_reg == '0) begin
            state_reg <= ST_FIN;
            q_reg     <= res_q;
            div0_reg  <= 1'b0;
            ovf_reg   <= res_ovf;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = (state_reg == ST_RUN);
  assign o_done = (state_reg == ST_FIN);
  assign o_q    = q_reg;
  assign o_div0 = div0_reg;
  assign o_ovf  = ovf_reg;

endmodule

// File: tb/tb_qr_fxp_divider.sv
// Testbench for qr_fxp_divider (Q8.8, signed). A saturating instance is the
// main DUT; a wrapping twin sees the same stimulus for the SAT=0 results.
module tb_qr_fxp_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div0, ovf;
  logic [W-1:0] q;
  logic         busy_w, done_w, div0_w, ovf_w;
  logic [W-1:0] q_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qr_fxp_divider #(.WIDTH(16), .FRAC(8), .SIGNED(1), .SAT(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b),
    .o_busy(busy), .o_done(done), .o_q(q), .o_div0(div0), .o_ovf(ovf)
  );

  qr_fxp_divider #(.WIDTH(16), .FRAC(8), .SIGNED(1), .SAT(0)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b),
    .o_busy(busy_w), .o_done(done_w), .o_q(q_w), .o_div0(div0_w), .o_ovf(ovf_w)
  );

  typedef struct {
    logic [15:0] a, b, q, qw;
    logic        d0, ov;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Start one division, then watch for o_done. lat is the cycle offset from
  // the accept cycle (-1 on timeout); result values are captured at o_done.
  task automatic do_op(input logic [15:0] va, input logic [15:0] vb,
                       output int lat, output int busy_cyc,
                       output logic [15:0] rq, output logic [15:0] rqw,
                       output logic rd0, output logic rov, output logic rov_w);
    @(posedge clk); #1;
    a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    lat = -1; busy_cyc = 0;
    rq = 'x; rqw = 'x; rd0 = 'x; rov = 'x; rov_w = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        lat = k; rq = q; rqw = q_w; rd0 = div0; rov = ovf; rov_w = ovf_w;
        break;
      end
    end
    @(negedge clk);
    check("done_single_pulse", done, 1'b0);
  endtask

  initial begin
    int lat, lat2, bc, dcnt;
    logic [15:0] rq, rqw;
    logic rd0, rov, rov_w;

    vecs[0]  = '{16'h0300, 16'h0200, 16'h0180, 16'h0180, 1'b0, 1'b0, 25};
    vecs[1]  = '{16'hFD00, 16'h0200, 16'hFE80, 16'hFE80, 1'b0, 1'b0, 25};
    vecs[2]  = '{16'h0100, 16'h0300, 16'h0055, 16'h0055, 1'b0, 1'b0, 25};
    vecs[3]  = '{16'hFF00, 16'h0300, 16'hFFAB, 16'hFFAB, 1'b0, 1'b0, 25};
    vecs[4]  = '{16'h0100, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1};
    vecs[5]  = '{16'h8000, 16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b0, 1};
    vecs[6]  = '{16'h7FFF, 16'h0001, 16'h7FFF, 16'hFF00, 1'b0, 1'b1, 25};
    vecs[7]  = '{16'h8000, 16'hFF00, 16'h7FFF, 16'h8000, 1'b0, 1'b1, 25};
    vecs[8]  = '{16'h8000, 16'h0100, 16'h8000, 16'h8000, 1'b0, 1'b0, 25};
    vecs[9]  = '{16'h8000, 16'h8000, 16'h0100, 16'h0100, 1'b0, 1'b0, 25};
    vecs[10] = '{16'h7FFF, 16'h8000, 16'hFF01, 16'hFF01, 1'b0, 1'b0, 25};
    vecs[11] = '{16'hFFFF, 16'h7FFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 25};
    vecs[12] = '{16'hFD00, 16'hFE00, 16'h0180, 16'h0180, 1'b0, 1'b0, 25};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_q", q, 16'h0000);
    check("rst_div0", div0, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    $display("reset: busy=%b done=%b q=%h div0=%b ovf=%b", busy, done, q, div0, ovf);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].a, vecs[i].b, lat, bc, rq, rqw, rd0, rov, rov_w);
      $display("vec %0d: a=%h b=%h q=%h q_wrap=%h div0=%b ovf=%b lat=%0d",
               i, vecs[i].a, vecs[i].b, rq, rqw, rd0, rov, lat);
      check("latency", lat, vecs[i].lat);
      check("busy_cycles", bc, vecs[i].lat - 1);
      check("q_sat", rq, vecs[i].q);
      check("q_wrap", rqw, vecs[i].qw);
      check("div0", rd0, vecs[i].d0);
      check("ovf", rov, vecs[i].ov);
      check("ovf_wrap", rov_w, vecs[i].ov);
    end

    // i_start during RUN must be ignored
    @(posedge clk); #1;
    a = 16'h0300; b = 16'h0200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; dcnt = 0; rq = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 5) begin start = 1'b1; a = 16'h0100; b = 16'h0300; end
      if (k == 6) start = 1'b0;
      if (done) begin
        if (lat < 0) begin lat = k; rq = q; end
        dcnt++;
      end
    end
    $display("start_in_run: q=%h lat=%0d done_pulses=%0d", rq, lat, dcnt);
    check("run_start_latency", lat, 25);
    check("run_start_q", rq, 16'h0180);
    check("run_start_pulses", dcnt, 1);

    // Back-to-back: second start raised during the FIN cycle
    @(posedge clk); #1;
    a = 16'h0100; b = 16'h0300; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; rq = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin lat = k; rq = q; break; end
    end
    check("b2b_first_latency", lat, 25);
    check("b2b_first_q", rq, 16'h0055);
    start = 1'b1; a = 16'hFD00; b = 16'h0200;
    @(posedge clk); #1;
    start = 1'b0;
    lat2 = -1; rqw = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("b2b_gap_done", done, 1'b0);
        check("b2b_gap_busy", busy, 1'b1);
      end
      if (done) begin lat2 = k; rqw = q; break; end
    end
    $display("back_to_back: q1=%h lat1=%0d q2=%h lat2=%0d", rq, lat, rqw, lat2);
    check("b2b_second_latency", lat2, 25);
    check("b2b_second_q", rqw, 16'hFE80);

    // Reset at RUN cycle 10
    @(posedge clk); #1;
    a = 16'h7FFF; b = 16'h8000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    check("midrun_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrun_rst_busy", busy, 1'b0);
    check("midrun_rst_done", done, 1'b0);
    check("midrun_rst_q", q, 16'h0000);
    check("midrun_rst_div0", div0, 1'b0);
    check("midrun_rst_ovf", ovf, 1'b0);
    dcnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    $display("midrun_reset: busy=%b q=%h stray_activity=%0d", busy, q, dcnt);
    check("midrun_no_done", dcnt, 0);
    do_op(16'h0300, 16'h0200, lat, bc, rq, rqw, rd0, rov, rov_w);
    $display("after_reset: q=%h lat=%0d", rq, lat);
    check("after_rst_latency", lat, 25);
    check("after_rst_q", rq, 16'h0180);
    check("after_rst_ovf", rov, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
